// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum and register-index width.
package hazard_pkg;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN,
        STALL
    } state_t;
endpackage

// File: rtl/hazard_controller_if.sv
// Hazard inputs from ID/EX/MEM and pipeline control outputs.
// master drives hazard sources, slave is the controller.
interface hazard_controller_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic [REG_W-1:0] EX_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic             MEM_Branch;
    logic             MEM_Zero;

    logic             PCSrc;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             EXMEM_Flush;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output ID_Rs, ID_Rt, EX_Rt,
        output ID_UsesRt, EX_MemRead,
        output MEM_Branch, MEM_Zero,
        input  PCSrc, PCWrite, IFID_Write,
        input  IFID_Flush, IDEX_Flush, EXMEM_Flush,
        input  StallCount, FlushCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, EX_Rt,
        input  ID_UsesRt, EX_MemRead,
        input  MEM_Branch, MEM_Zero,
        output PCSrc, PCWrite, IFID_Write,
        output IFID_Flush, IDEX_Flush, EXMEM_Flush,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    output logic [width-1:0] count
);
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_controller.sv
// Load-use stall and taken-branch flush controller.
// Outputs are combinational from inputs and the RUN/STALL state.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    hazard_controller_if.slave  hz
);
    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] left;
    logic [1:0] left_nx;

    logic taken;
    logic load_use;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;

    assign taken = hz.MEM_Branch & hz.MEM_Zero;

    assign load_use = hz.EX_MemRead
                   && (hz.EX_Rt != REG_ZERO)
                   && ((hz.EX_Rt == hz.ID_Rs)
                    || (hz.ID_UsesRt && (hz.EX_Rt == hz.ID_Rt)));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= RUN;
            left  <= '0;
        end else begin
            state <= state_nx;
            left  <= left_nx;
        end
    end

    always_comb begin
        state_nx    = RUN;
        left_nx     = '0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!Rst) begin
            state_nx = RUN;
        end else if (taken) begin
            // A taken branch squashes everything younger, including a stall.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (left != 2'd1) begin
                state_nx = STALL;
                left_nx  = left - 2'd1;
            end
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nx = STALL;
                left_nx  = STALL_INIT;
            end
        end
    end

    assign hz.PCSrc       = taken;
    assign hz.PCWrite     = pc_write;
    assign hz.IFID_Write  = ifid_write;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.IDEX_Flush  = idex_flush;
    assign hz.EXMEM_Flush = exmem_flush;

    sat_counter #(.width(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (~pc_write),
        .count (hz.StallCount)
    );

    sat_counter #(.width(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (taken),
        .count (hz.FlushCount)
    );
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: three controller configurations share one stimulus
// stream; a reference model pushes expected outputs per cycle.
module tb_hazard_controller;
    typedef struct {
        logic [5:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    logic Clk;
    logic Rst;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];

    int m_state[3];
    int m_left[3];
    int m_sc[3];
    int m_fc[3];
    int m_len[3] = '{1, 3, 1};
    int m_max[3] = '{65535, 65535, 15};

    hazard_controller_if #(.CNT_W(16)) if1 ();
    hazard_controller_if #(.CNT_W(16)) if3 ();
    hazard_controller_if #(.CNT_W(4))  ifs ();

    hazard_controller #(
        .LOAD_STALL_CYCLES(1), .CNT_W(16)
    ) dut1 (.Clk(Clk), .Rst(Rst), .hz(if1.slave));

    hazard_controller #(
        .LOAD_STALL_CYCLES(3), .CNT_W(16)
    ) dut3 (.Clk(Clk), .Rst(Rst), .hz(if3.slave));

    hazard_controller #(
        .LOAD_STALL_CYCLES(1), .CNT_W(4)
    ) duts (.Clk(Clk), .Rst(Rst), .hz(ifs.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl_of(int d);
        case (d)
            0: return {if1.PCSrc, if1.PCWrite, if1.IFID_Write,
                       if1.IFID_Flush, if1.IDEX_Flush,
                       if1.EXMEM_Flush};
            1: return {if3.PCSrc, if3.PCWrite, if3.IFID_Write,
                       if3.IFID_Flush, if3.IDEX_Flush,
                       if3.EXMEM_Flush};
            default: return {ifs.PCSrc, ifs.PCWrite,
                             ifs.IFID_Write, ifs.IFID_Flush,
                             ifs.IDEX_Flush, ifs.EXMEM_Flush};
        endcase
    endfunction

    function automatic logic [31:0] sc_of(int d);
        case (d)
            0: return 32'(if1.StallCount);
            1: return 32'(if3.StallCount);
            default: return 32'(ifs.StallCount);
        endcase
    endfunction

    function automatic logic [31:0] fc_of(int d);
        case (d)
            0: return 32'(if1.FlushCount);
            1: return 32'(if3.FlushCount);
            default: return 32'(ifs.FlushCount);
        endcase
    endfunction

    task automatic step(bit rst, bit [4:0] rs, bit [4:0] rt,
                        bit ut, bit mr, bit [4:0] ert,
                        bit br, bit z);
        bit   taken;
        bit   lu;
        exp_t e;
        @(negedge Clk);
        Rst = rst;
        if1.ID_Rs = rs;  if3.ID_Rs = rs;  ifs.ID_Rs = rs;
        if1.ID_Rt = rt;  if3.ID_Rt = rt;  ifs.ID_Rt = rt;
        if1.ID_UsesRt = ut;  if3.ID_UsesRt = ut;
        ifs.ID_UsesRt = ut;
        if1.EX_MemRead = mr;  if3.EX_MemRead = mr;
        ifs.EX_MemRead = mr;
        if1.EX_Rt = ert;  if3.EX_Rt = ert;  ifs.EX_Rt = ert;
        if1.MEM_Branch = br;  if3.MEM_Branch = br;
        ifs.MEM_Branch = br;
        if1.MEM_Zero = z;  if3.MEM_Zero = z;  ifs.MEM_Zero = z;

        taken = br & z;
        lu = mr && (ert != 0)
             && ((ert == rs) || (ut && (ert == rt)));
        for (int d = 0; d < 3; d++) begin
            bit pw, iw, f1, f2, f3;
            int ns, nl;
            pw = 1; iw = 1; f1 = 0; f2 = 0; f3 = 0;
            ns = 0; nl = 0;
            if (!rst) begin
                ns = 0;
            end else if (taken) begin
                f1 = 1; f2 = 1; f3 = 1;
            end else if (m_state[d] == 1) begin
                pw = 0; iw = 0; f2 = 1;
                if (m_left[d] != 1) begin
                    ns = 1; nl = m_left[d] - 1;
                end
            end else if (lu) begin
                pw = 0; iw = 0; f2 = 1;
                if (m_len[d] > 1) begin
                    ns = 1; nl = m_len[d] - 1;
                end
            end
            e.ctl = {taken, pw, iw, f1, f2, f3};
            e.sc  = m_sc[d];
            e.fc  = m_fc[d];
            sb_q.push_back(e);
            if (!rst) begin
                m_sc[d] = 0;
                m_fc[d] = 0;
            end else begin
                if (!pw && m_sc[d] < m_max[d]) m_sc[d]++;
                if (taken && m_fc[d] < m_max[d]) m_fc[d]++;
            end
            m_state[d] = ns;
            m_left[d]  = nl;
        end

        #1;
        for (int d = 0; d < 3; d++) begin
            e = sb_q.pop_front();
            check($sformatf("ctl%0d", d), 32'(ctl_of(d)),
                  32'(e.ctl));
            check($sformatf("stall_cnt%0d", d), sc_of(d),
                  32'(e.sc));
            check($sformatf("flush_cnt%0d", d), fc_of(d),
                  32'(e.fc));
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hazard();
        step(1, 5, 0, 0, 1, 5, 0, 0);
    endtask

    initial begin
        Rst = 1'b0;
        if1.ID_Rs = 0;  if3.ID_Rs = 0;  ifs.ID_Rs = 0;
        if1.ID_Rt = 0;  if3.ID_Rt = 0;  ifs.ID_Rt = 0;
        if1.ID_UsesRt = 0;  if3.ID_UsesRt = 0;
        ifs.ID_UsesRt = 0;
        if1.EX_MemRead = 0;  if3.EX_MemRead = 0;
        ifs.EX_MemRead = 0;
        if1.EX_Rt = 0;  if3.EX_Rt = 0;  ifs.EX_Rt = 0;
        if1.MEM_Branch = 0;  if3.MEM_Branch = 0;
        ifs.MEM_Branch = 0;
        if1.MEM_Zero = 0;  if3.MEM_Zero = 0;  ifs.MEM_Zero = 0;
        for (int d = 0; d < 3; d++) begin
            m_state[d] = 0; m_left[d] = 0;
            m_sc[d] = 0;    m_fc[d] = 0;
        end

        // reset, including a taken branch while held in reset
        do_reset();
        step(0, 5, 0, 0, 1, 5, 1, 1);
        do_reset();
        idle();
        check("rst_stall_cnt", sc_of(0), 0);
        check("rst_flush_cnt", fc_of(0), 0);

        // single load-use hazard
        hazard();
        repeat (4) idle();
        check("lu_len1_cnt", sc_of(0), 1);
        check("lu_len3_cnt", sc_of(1), 3);

        // r0 and unused-Rt must not stall; used Rt must
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 3, 7, 0, 1, 7, 0, 0);
        step(1, 3, 7, 1, 1, 7, 0, 0);
        repeat (3) idle();
        check("rt_used_cnt", sc_of(1), 3);

        // branch wins over a simultaneous load-use
        do_reset();
        step(1, 5, 0, 0, 1, 5, 1, 1);
        idle();
        check("br_lu_flush", fc_of(0), 1);
        check("br_lu_stall", sc_of(0), 0);

        // branch in second stall cycle aborts the stall
        do_reset();
        hazard();
        step(1, 0, 0, 0, 0, 0, 1, 1);
        idle();
        idle();
        check("abort_stall_cnt", sc_of(1), 1);

        // reset in the middle of a stall
        hazard();
        do_reset();
        idle();
        idle();
        check("mid_rst_cnt", sc_of(1), 0);

        // flush counter saturation on the narrow instance
        do_reset();
        repeat (20) step(1, 0, 0, 0, 0, 0, 1, 1);
        idle();
        check("sat_flush4", fc_of(2), 15);
        check("flush16", fc_of(0), 20);

        // random traffic over a small register range
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 40) != 0,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, number of bubble cycles inserted per load-use hazard (legal 1..3).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-005 ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-006 ID_UsesRt  in  1  ID instruction reads Rt as a source.
REQ-007 EX_MemRead  in  1  instruction in EX is a load.
REQ-008 EX_Rt  in  5  destination register of the load in EX.
REQ-009 MEM_Branch, MEM_Zero  in  1 each  branch flag and ALU zero of the instruction in MEM.
REQ-010 PCSrc  out  1  select branch target for the next PC.
REQ-011 PCWrite, IFID_Write  out  1 each  enables for PC and IF/ID.
REQ-012 IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  zero the control fields of that pipeline register on the next edge.
REQ-013 StallCount, FlushCount  out  CNT_W each  saturating performance counters.

Function
REQ-014 Taken = MEM_Branch AND MEM_Zero; PCSrc SHALL equal Taken combinationally in every state.
REQ-015 LoadUse = EX_MemRead AND EX_Rt != 0 AND (EX_Rt == ID_Rs OR (ID_UsesRt AND EX_Rt == ID_Rt)).
REQ-016 FSM states: RUN, STALL; STALL holds a down-counter StallLeft (2 bits).
REQ-017 RUN with Taken: PCSrc=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, PCWrite=IFID_Write=1; next state RUN.
REQ-018 RUN with LoadUse and not Taken: PCWrite=0, IFID_Write=0, IDEX_Flush=1; if LOAD_STALL_CYCLES>1, next state STALL with StallLeft=LOAD_STALL_CYCLES-1, else remain RUN.
REQ-019 RUN with neither: PCWrite=IFID_Write=1, all flushes 0.
REQ-020 STALL without Taken: PCWrite=0, IFID_Write=0, IDEX_Flush=1; StallLeft decrements; when StallLeft==1 next state RUN.
REQ-021 STALL with Taken: branch wins; outputs as REQ-017; stall aborted, next state RUN, StallLeft cleared.
REQ-022 Taken and LoadUse in the same cycle: Taken wins; no stall cycle counted.
REQ-023 LoadUse is ignored while in STALL (re-evaluated once back in RUN).
REQ-024 StallCount increments by 1 every cycle PCWrite=0; FlushCount increments by 1 every cycle Taken=1; both saturate at all-ones, never wrap.
REQ-025 Total latency from hazard inputs to control outputs is zero cycles (combinational from inputs and state); only state and counters are registered.

Reset
REQ-026 While Rst=0 at an edge: state=RUN, StallLeft=0, StallCount=0, FlushCount=0.
REQ-027 During reset cycles outputs SHALL be PCWrite=1, IFID_Write=1, all flushes 0, PCSrc=Taken; reset mid-STALL returns to RUN on that edge.

Structure
REQ-028 Shared package hazard_pkg holds the state enum (RUN, STALL), REG_ZERO=5'd0, and the register-index width 5.
REQ-029 One sub-module sat_counter (parameter width, inputs Clk, Rst, inc; output count) instantiated twice for the counters.
REQ-030 FSM next-state and output decode in one combinational block; no latches.

Verification
REQ-031 LOAD_STALL_CYCLES=1, EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> PCWrite=0, IFID_Write=0, IDEX_Flush=1 that cycle only; StallCount=1.
REQ-032 LOAD_STALL_CYCLES=3, same hazard -> three consecutive stall cycles, then RUN; StallCount=3.
REQ-033 EX_Rt=0 matching ID_Rs=0 with EX_MemRead=1 -> no stall; ID_UsesRt=0 with EX_Rt==ID_Rt -> no stall.
REQ-034 MEM_Branch=1, MEM_Zero=1 with simultaneous LoadUse -> PCSrc=1, all three flushes 1, PCWrite=1; FlushCount=1, StallCount unchanged.
REQ-035 LOAD_STALL_CYCLES=3, Taken in second stall cycle -> flush outputs that cycle, RUN next cycle; StallCount=1; reset asserted mid-STALL -> RUN, counters 0.
REQ-036 CNT_W=4, 20 taken branches -> FlushCount holds at 15.
